bram_delay_ctrl: RTL
====================

Name: bram_delay_ctrl

Overview:
- Controller that runs an external simple-dual-port block RAM as a programmable-length streaming delay line.
- Each output sample equals the input sample accepted L accepts earlier.
- Sits between a valid/ready producer, a valid/ready consumer and one SDP RAM with 1-cycle read latency and registered data out held while rd_en is low.
- Sequences RAM addresses and enables, tracks fill level, applies backpressure and drains on request.

Parameters:
DATA_WIDTH, 25, sample width in bits.
ADDR_WIDTH, 9, RAM address width; maximum delay length is 2^ADDR_WIDTH-1.

Ports:
clk  in  1  single clock; all logic is on the rising edge.
rst  in  1  asynchronous, active-high reset.
cfg_len  in  ADDR_WIDTH  delay length L; sampled only on cfg_load in IDLE.
cfg_load  in  1  single-cycle pulse that starts operation with cfg_len.
drain  in  1  single-cycle pulse that empties the delay line and returns to IDLE.
busy  out  1  high in every state except IDLE.
s_valid  in  1  input sample valid.
s_data  in  DATA_WIDTH  input sample.
s_ready  out  1  controller accepts input this cycle.
m_valid  out  1  output sample valid.
m_data  out  DATA_WIDTH  output sample, driven directly from ram_rd_data.
m_ready  in  1  consumer accepts output this cycle.
ram_wr_en  out  1  RAM write enable.
ram_wr_addr  out  ADDR_WIDTH  RAM write address, equal to wr_ptr.
ram_wr_data  out  DATA_WIDTH  RAM write data, equal to s_data.
ram_rd_en  out  1  RAM read enable.
ram_rd_addr  out  ADDR_WIDTH  RAM read address, equal to rd_ptr.
ram_rd_data  in  DATA_WIDTH  RAM read data, valid 1 cycle after ram_rd_en.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; wr_ptr=rd_ptr=fill=len_q=0.
  - m_valid=0, s_ready=0, busy=0, ram_wr_en=0, ram_rd_en=0.
- Definitions: acc = s_valid & s_ready; slot_free = !m_valid | m_ready.
- ram_wr_en=acc. ram_rd_en is asserted as defined per state below.
- On every read: rd_ptr++. On every write: wr_ptr++. All pointer arithmetic wraps mod 2^ADDR_WIDTH.
- Next-cycle m_valid:
  - 1 if ram_rd_en this cycle;
  - otherwise 0 if m_ready this cycle;
  - otherwise it holds.
- Latency: input-accept to output-valid is exactly 1 cycle once RUN; a sample accepted at accept n is output at accept n+L.
- IDLE:
  - s_ready=0.
  - cfg_load with cfg_len!=0: len_q<=cfg_len, wr_ptr=rd_ptr=fill=0, go to FILL.
  - cfg_load with cfg_len==0: ignored, stay in IDLE.
- FILL:
  - s_ready=1; no reads.
  - Each acc: fill++.
  - acc when fill==len_q-1: go to RUN (fill becomes len_q).
- RUN:
  - s_ready=slot_free.
  - Each acc writes and reads in the same cycle; rd_ptr trails wr_ptr by len_q.
  - fill stays at len_q.
  - rd_addr never equals wr_addr because 1<=L<2^ADDR_WIDTH.
- DRAIN:
  - Entered from FILL or RUN on drain (drain has priority over acc in that cycle).
  - s_ready=0; ram_rd_en=slot_free & (fill!=0); fill-- on each read.
  - When fill==0 and m_valid==0, go to IDLE.
  - Drain entered with fill==0 reaches IDLE on the next cycle.
- Pulse handling:
  - cfg_load outside IDLE is ignored.
  - drain in IDLE is ignored.
  - drain in DRAIN is ignored.
- Reset mid-operation: all in-flight data is discarded; RAM contents are irrelevant.
- The length is frozen in len_q; changing cfg_len while busy has no effect.

Optional Feature:
- Macro: BRAM_DELAY_CTRL_ZERO_FILL_EN.
- Defined:
  - In FILL, s_ready=slot_free, and each acc also produces one output with data 0 (m_valid=1 next cycle, m_data forced to 0 via a zero_q flag).
  - This gives a rate-matched output from the first input.
  - Drain still emits real data.
- Undefined: FILL produces no output; zero_q logic is absent.

Decomposition:
- Package bram_delay_ctrl_pkg:
  - state enum {IDLE, FILL, RUN, DRAIN};
  - default-width localparams.
- Sub-module bram_delay_ptr:
  - wrap-around pointer pair plus fill counter, with inc_wr/inc_rd/clear inputs;
  - instantiated once.
- The state machine and handshake logic live in the top.

Test Plan:
- Reset, then cfg_load with cfg_len=4 and input 1,2,3,... at full rate with m_ready=1 -> no output for the first 4 accepts; then m_data=1,2,3,... with output valid 1 cycle after accepts 5,6,7.
- RUN with L=3, m_ready held low 5 cycles -> s_ready=0 after one pending output, no RAM read/write during the stall, no data lost or duplicated after release.
- L=511 (max) with 1500 inputs -> outputs exactly input minus 511 across pointer wrap; rd_addr never equals wr_addr.
- L=4, 6 inputs, then drain -> outputs 3,4,5,6 (the 4 buffered), then busy=0; cfg_load with cfg_len=0 -> stays IDLE.
- drain during FILL after 2 of L=8 inputs -> outputs the 2 samples in order, then IDLE; cfg_load while busy -> ignored.
- rst asserted mid-RUN -> m_valid=0 and busy=0 immediately (asynchronous); new cfg_load with L=2 -> correct delay from an empty line. With BRAM_DELAY_CTRL_ZERO_FILL_EN and L=3: inputs 7,8,9,10 -> outputs 0,0,0,7.

Source files
------------

// File: rtl/bram_delay_ctrl_pkg.sv
// Shared types and default widths for the BRAM delay-line controller.
//   state_e       : controller states
//   DefDataWidth  : default sample width
//   DefAddrWidth  : default RAM address width (max delay 2^AW-1)
package bram_delay_ctrl_pkg;

   localparam int unsigned DefDataWidth = 25;
   localparam int unsigned DefAddrWidth = 9;

   typedef enum logic [1:0] {
      StIdle,
      StFill,
      StRun,
      StDrain
   } state_e;

endpackage

// File: rtl/bram_delay_ptr.sv
// Wrap-around write/read pointer pair plus fill counter for the delay line.
//   clk_i, rst_i        : clock, asynchronous active-high reset
//   clear_i             : zero both pointers and the fill count
//   inc_wr_i / inc_rd_i : advance write / read pointer by one
//   wr_ptr_o, rd_ptr_o  : current RAM write / read addresses
//   fill_o              : samples currently held in the line (writes minus reads)
module bram_delay_ptr
   import bram_delay_ctrl_pkg::*;
#(
   parameter int unsigned AddrWidth = DefAddrWidth
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 clear_i,
   input  logic                 inc_wr_i,
   input  logic                 inc_rd_i,
   output logic [AddrWidth-1:0] wr_ptr_o,
   output logic [AddrWidth-1:0] rd_ptr_o,
   output logic [AddrWidth-1:0] fill_o
);

   logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
   logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
   logic [AddrWidth-1:0] fill_q, fill_d;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      fill_d   = fill_q;
      if (clear_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         fill_d   = '0;
      end else begin
         if (inc_wr_i) wr_ptr_d = wr_ptr_q + AddrWidth'(1);
         if (inc_rd_i) rd_ptr_d = rd_ptr_q + AddrWidth'(1);
         // A simultaneous write and read leaves the occupancy unchanged.
         if (inc_wr_i && !inc_rd_i) begin
            fill_d = fill_q + AddrWidth'(1);
         end else if (inc_rd_i && !inc_wr_i) begin
            fill_d = fill_q - AddrWidth'(1);
         end
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         fill_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         fill_q   <= fill_d;
      end
   end

   assign wr_ptr_o = wr_ptr_q;
   assign rd_ptr_o = rd_ptr_q;
   assign fill_o   = fill_q;

endmodule

// File: rtl/bram_delay_ctrl.sv
// Runs an external simple-dual-port RAM (1-cycle registered read) as a
// programmable-length streaming delay line: output n equals input n-L.
//   cfg_len/cfg_load : load length L (non-zero) and start, only from idle
//   drain            : flush buffered samples to the output, then go idle
//   busy             : controller not idle
//   s_*              : valid/ready input stream
//   m_*              : valid/ready output stream, m_data straight from RAM
//   ram_*            : RAM write port (wr_ptr) and read port (rd_ptr)
// Optional build macro BRAM_DELAY_CTRL_ZERO_FILL_EN: during fill every
// accepted input also emits a zero sample so the output is rate-matched.
module bram_delay_ctrl
   import bram_delay_ctrl_pkg::*;
#(
   parameter int unsigned DATA_WIDTH = DefDataWidth,
   parameter int unsigned ADDR_WIDTH = DefAddrWidth
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [ADDR_WIDTH-1:0] cfg_len,
   input  logic                  cfg_load,
   input  logic                  drain,
   output logic                  busy,
   input  logic                  s_valid,
   input  logic [DATA_WIDTH-1:0] s_data,
   output logic                  s_ready,
   output logic                  m_valid,
   output logic [DATA_WIDTH-1:0] m_data,
   input  logic                  m_ready,
   output logic                  ram_wr_en,
   output logic [ADDR_WIDTH-1:0] ram_wr_addr,
   output logic [DATA_WIDTH-1:0] ram_wr_data,
   output logic                  ram_rd_en,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data
);

   state_e                state_q, state_d;
   logic [ADDR_WIDTH-1:0] len_q, len_d;
   logic                  m_valid_q, m_valid_d;
   logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr, fill;
   logic                  acc, rd_en, slot_free, clear, emit;

   assign slot_free = !m_valid_q || m_ready;

   // Handshake and read enable. drain blocks acceptance so it wins over acc.
   always_comb begin
      s_ready = 1'b0;
      rd_en   = 1'b0;
      unique case (state_q)
         StIdle: s_ready = 1'b0;
         StFill: begin
`ifdef BRAM_DELAY_CTRL_ZERO_FILL_EN
            s_ready = slot_free && !drain;
`else
            s_ready = !drain;
`endif
         end
         StRun: begin
            s_ready = slot_free && !drain;
            rd_en   = s_valid && s_ready;
         end
         StDrain: rd_en = slot_free && (fill != '0);
         default: s_ready = 1'b0;
      endcase
   end

   assign acc = s_valid && s_ready;

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      clear   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (cfg_load && (cfg_len != '0)) begin
               len_d   = cfg_len;
               clear   = 1'b1;
               state_d = StFill;
            end
         end
         StFill: begin
            if (drain) begin
               state_d = StDrain;
            end else if (acc && (fill == len_q - ADDR_WIDTH'(1))) begin
               state_d = StRun;
            end
         end
         StRun: begin
            if (drain) state_d = StDrain;
         end
         StDrain: begin
            if ((fill == '0) && !m_valid_q) state_d = StIdle;
         end
         default: state_d = StIdle;
      endcase
   end

`ifdef BRAM_DELAY_CTRL_ZERO_FILL_EN
   // zero_q marks the sample on m_data as a synthetic fill zero rather than
   // RAM data; it clears as soon as a real read replaces it.
   logic zero_emit, zero_q, zero_d;

   assign zero_emit = (state_q == StFill) && acc;
   assign emit      = rd_en || zero_emit;

   always_comb begin
      zero_d = zero_q;
      if (zero_emit) begin
         zero_d = 1'b1;
      end else if (rd_en) begin
         zero_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) zero_q <= 1'b0;
      else     zero_q <= zero_d;
   end

   assign m_data = zero_q ? '0 : ram_rd_data;
`else
   assign emit   = rd_en;
   assign m_data = ram_rd_data;
`endif

   always_comb begin
      m_valid_d = m_valid_q;
      if (emit) begin
         m_valid_d = 1'b1;
      end else if (m_ready) begin
         m_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         len_q     <= '0;
         m_valid_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         len_q     <= len_d;
         m_valid_q <= m_valid_d;
      end
   end

   bram_delay_ptr #(
      .AddrWidth(ADDR_WIDTH)
   ) u_ptr (
      .clk_i   (clk),
      .rst_i   (rst),
      .clear_i (clear),
      .inc_wr_i(acc),
      .inc_rd_i(rd_en),
      .wr_ptr_o(wr_ptr),
      .rd_ptr_o(rd_ptr),
      .fill_o  (fill)
   );

   assign busy        = (state_q != StIdle);
   assign m_valid     = m_valid_q;
   assign ram_wr_en   = acc;
   assign ram_wr_addr = wr_ptr;
   assign ram_wr_data = s_data;
   assign ram_rd_en   = rd_en;
   assign ram_rd_addr = rd_ptr;

endmodule
